ldpc_frame_ctrl: RTL and testbench

Parametrised frame controller for the 802.11ay layered LDPC decoder. It accepts channel LLRs one Z-wide column per beat into an internal column buffer, and sequences the decoding core one iteration at a time. It stops on iteration limit or on a zero-syndrome early termination. It then streams the hard-decided information columns out under a ready/valid handshake with backpressure. It sits between the LLR front end and the layered check/variable node core, and replaces ad-hoc input capture and fixed 8-column output logic with rate-dependent, flow-controlled I/O.

---
 rtl/ldpc_frame_ctrl_if.sv | 51 +++++
 rtl/ldpc_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ldpc_frame_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_frame_ctrl_if.sv
// Bundled I/O of the LDPC frame controller: LLR input beats, the decoding
// core control and posterior read port, the hard-decision output stream and
// the frame statistics. The slave modport is the controller's view.
interface ldpc_frame_ctrl_if #(
  parameter int Z          = 42,
  parameter int WIDTH_LLR  = 6,
  parameter int NUM_COLS   = 16,
  parameter int WIDTH_COL  = 4,
  parameter int WIDTH_ITER = 5,
  parameter int WIDTH_RATE = 2
) ();

  logic [WIDTH_RATE-1:0]           rate;
  logic [WIDTH_ITER-1:0]           iter_max;
  logic [Z*WIDTH_LLR-1:0]          llr_in;
  logic [WIDTH_COL-1:0]            llr_in_col;
  logic                            llr_in_valid;
  logic                            llr_in_last;
  logic                            llr_in_ready;
  logic [NUM_COLS*Z*WIDTH_LLR-1:0] llr_ch;
  logic                            core_start;
  logic                            core_iter_done;
  logic                            core_syndrome_ok;
  logic [WIDTH_COL-1:0]            post_col_sel;
  logic [Z*WIDTH_LLR-1:0]          post_llr;
  logic [Z-1:0]                    data_out;
  logic [WIDTH_COL-1:0]            data_col;
  logic                            data_valid;
  logic                            data_last;
  logic                            data_ready;
  logic                            frame_done;
  logic [WIDTH_ITER-1:0]           stat_iters;
  logic                            stat_early;

  modport master (
    output rate, iter_max, llr_in, llr_in_col, llr_in_valid, llr_in_last,
    output core_iter_done, core_syndrome_ok, post_llr, data_ready,
    input  llr_in_ready, llr_ch, core_start, post_col_sel,
    input  data_out, data_col, data_valid, data_last, frame_done,
    input  stat_iters, stat_early
  );

  modport slave (
    input  rate, iter_max, llr_in, llr_in_col, llr_in_valid, llr_in_last,
    input  core_iter_done, core_syndrome_ok, post_llr, data_ready,
    output llr_in_ready, llr_ch, core_start, post_col_sel,
    output data_out, data_col, data_valid, data_last, frame_done,
    output stat_iters, stat_early
  );

endinterface

// File: rtl/ldpc_frame_ctrl.sv
// Frame controller for the layered LDPC decoder: captures channel LLR columns,
// runs the core one iteration at a time until the limit or a clean syndrome,
// then streams the hard-decided information columns with backpressure.
module ldpc_frame_ctrl #(
  parameter int Z          = 42,
  parameter int WIDTH_LLR  = 6,
  parameter int NUM_COLS   = 16,
  parameter int WIDTH_COL  = 4,
  parameter int WIDTH_ITER = 5,
  parameter int WIDTH_RATE = 2
) (
  input logic              clk,
  input logic              reset,
  ldpc_frame_ctrl_if.slave bus
);

  localparam int                 LLR_COL_W = Z * WIDTH_LLR;
  localparam logic [WIDTH_COL:0] COL_LIMIT = (WIDTH_COL + 1)'(NUM_COLS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ITER,
    S_OUT
  } frameStateT;

  frameStateT r_state;
  frameStateT w_stateNext;

  logic [NUM_COLS-1:0][LLR_COL_W-1:0] r_llrBuf;
  logic [WIDTH_RATE-1:0]              r_rate;
  logic [WIDTH_ITER-1:0]              r_iterMax;
  logic [WIDTH_ITER-1:0]              r_iterCnt;
  logic                               r_early;
  logic                               r_coreStart;
  logic                               r_frameDone;
  logic [WIDTH_COL-1:0]               r_outCol;

  logic                  w_inReady;
  logic                  w_outValid;
  logic                  w_beatAccept;
  logic                  w_lastAccept;
  logic                  w_iterDone;
  logic                  w_iterEnd;
  logic                  w_outHandshake;
  logic                  w_outFinal;
  logic [WIDTH_ITER-1:0] w_iterNext;
  logic [WIDTH_ITER-1:0] w_effMax;
  logic [WIDTH_COL-1:0]  w_kLast;
  logic [Z-1:0]          w_hard;

  assign w_beatAccept   = bus.llr_in_valid && w_inReady;
  assign w_lastAccept   = w_beatAccept && bus.llr_in_last;
  assign w_iterDone     = (r_state == S_ITER) && bus.core_iter_done;
  assign w_iterNext     = r_iterCnt + WIDTH_ITER'(1);
  assign w_effMax       = (r_iterMax == '0) ? WIDTH_ITER'(1) : r_iterMax;
  assign w_iterEnd      = bus.core_syndrome_ok || (w_iterNext == w_effMax);
  assign w_outHandshake = w_outValid && bus.data_ready;
  assign w_outFinal     = w_outHandshake && (r_outCol == w_kLast);

  // Number of information columns to emit, expressed as the last column index.
  always_comb begin
    w_kLast = WIDTH_COL'(7);
    case (r_rate)
      WIDTH_RATE'(1): w_kLast = WIDTH_COL'(9);
      WIDTH_RATE'(2): w_kLast = WIDTH_COL'(11);
      WIDTH_RATE'(3): w_kLast = WIDTH_COL'(12);
      default:        w_kLast = WIDTH_COL'(7);
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_stateNext;
  end

  // Next-state logic and state-decoded handshake strobes.
  always_comb begin
    w_stateNext = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_inReady = 1'b1;
        if (bus.llr_in_valid && bus.llr_in_last) w_stateNext = S_ITER;
      end
      S_ITER: begin
        if (bus.core_iter_done && w_iterEnd) w_stateNext = S_OUT;
      end
      S_OUT: begin
        w_outValid = 1'b1;
        if (bus.data_ready && (r_outCol == w_kLast)) w_stateNext = S_LOAD;
      end
      default: w_stateNext = S_LOAD;
    endcase
  end

  // Column buffer write; out-of-range columns are swallowed, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_beatAccept && ({1'b0, bus.llr_in_col} < COL_LIMIT)) begin
      r_llrBuf[bus.llr_in_col] <= bus.llr_in;
    end
  end

  // Frame parameters latched with the last beat, plus iteration statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rate    <= '0;
      r_iterMax <= '0;
      r_iterCnt <= '0;
      r_early   <= 1'b0;
    end else if (w_lastAccept) begin
      r_rate    <= bus.rate;
      r_iterMax <= bus.iter_max;
      r_iterCnt <= '0;
      r_early   <= 1'b0;
    end else if (w_iterDone) begin
      r_iterCnt <= w_iterNext;
      if (bus.core_syndrome_ok) r_early <= 1'b1;
    end
  end

  // Single-cycle pulses: iteration launch and end-of-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coreStart <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_coreStart <= w_lastAccept || (w_iterDone && !w_iterEnd);
      r_frameDone <= w_outFinal;
    end
  end

  // Output column counter, advanced by each accepted beat and wrapped after the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outCol <= '0;
    end else if (w_outHandshake) begin
      r_outCol <= w_outFinal ? '0 : r_outCol + WIDTH_COL'(1);
    end
  end

  // Hard decision per lane: a bit is 1 when the posterior LLR is zero or negative.
  always_comb begin
    w_hard = '0;
    for (int i = 0; i < Z; i++) begin
      w_hard[i] = bus.post_llr[i*WIDTH_LLR + WIDTH_LLR - 1] |
                  ~(|bus.post_llr[i*WIDTH_LLR +: WIDTH_LLR]);
    end
  end

  assign bus.llr_in_ready = w_inReady;
  assign bus.llr_ch       = r_llrBuf;
  assign bus.core_start   = r_coreStart && !reset;
  assign bus.post_col_sel = r_outCol;
  assign bus.data_out     = w_hard;
  assign bus.data_col     = r_outCol;
  assign bus.data_valid   = w_outValid;
  assign bus.data_last    = w_outValid && (r_outCol == w_kLast);
  assign bus.frame_done   = r_frameDone;
  assign bus.stat_iters   = r_iterCnt;
  assign bus.stat_early   = r_early;

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Self-checking bench for ldpc_frame_ctrl: a behavioural decoding-core model,
// a frame-level expectation model and one output compare process.
module tb_ldpc_frame_ctrl;

  localparam int Z        = 42;
  localparam int W        = 6;
  localparam int NC       = 16;
  localparam int WC       = 4;
  localparam int WI       = 5;
  localparam int WR       = 2;
  localparam int CORE_LAT = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ldpc_frame_ctrl_if #(
    .Z(Z), .WIDTH_LLR(W), .NUM_COLS(NC), .WIDTH_COL(WC),
    .WIDTH_ITER(WI), .WIDTH_RATE(WR)
  ) bus ();

  ldpc_frame_ctrl #(
    .Z(Z), .WIDTH_LLR(W), .NUM_COLS(NC), .WIDTH_COL(WC),
    .WIDTH_ITER(WI), .WIDTH_RATE(WR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int             postVal[NC][Z];
  logic [Z*W-1:0] chModel[NC];
  bit             chValid[NC];
  int             expQ[$];
  int             expK, expIters, effMax, syndAt;
  bit             expEarly;
  int             startCount, iterNum, beatCount;
  int             readyMode;

  // Generic scalar comparison with failure report.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Comparison for one full LLR column.
  task automatic checkWide(input string name, input logic [Z*W-1:0] act, input logic [Z*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference hard decision straight from the integer posterior values.
  function automatic logic [Z-1:0] hardOf(input int col);
    logic [Z-1:0] r;
    for (int i = 0; i < Z; i++) r[i] = (postVal[col][i] <= 0);
    return r;
  endfunction

  // Core posterior read port: combinational lookup of the selected column.
  always_comb begin
    bus.post_llr = '0;
    for (int i = 0; i < Z; i++) bus.post_llr[i*W +: W] = W'(postVal[bus.post_col_sel][i]);
  end

  // Decoding core model: fixed latency per iteration, syndrome on a chosen iteration.
  initial begin : coreModel
    bit running, aborted, fire, term;
    bus.core_iter_done   = 1'b0;
    bus.core_syndrome_ok = 1'b0;
    forever begin
      @(negedge clk); #1;
      running = !reset && bus.core_start;
      while (running) begin
        startCount++;
        iterNum++;
        aborted = 1'b0;
        for (int k = 0; k < CORE_LAT - 1 && !aborted; k++) begin
          @(negedge clk); #1;
          if (reset) aborted = 1'b1;
          else checkOutput("start_one_cycle", bus.core_start, 0);
        end
        if (aborted) begin
          running = 1'b0;
        end else begin
          fire = (syndAt != 0) && (iterNum == syndAt);
          term = fire || (iterNum == effMax);
          bus.core_iter_done   = 1'b1;
          bus.core_syndrome_ok = fire;
          @(negedge clk); #1;
          bus.core_iter_done   = 1'b0;
          bus.core_syndrome_ok = 1'b0;
          if (reset) begin
            running = 1'b0;
          end else if (term) begin
            checkOutput("valid_after_term", bus.data_valid, 1);
            checkOutput("no_start_after_term", bus.core_start, 0);
            running = 1'b0;
          end else begin
            checkOutput("start_after_done", bus.core_start, 1);
            running = bus.core_start;
          end
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = repeating 1,0,0,1, 2 = never ready.
  initial begin : readyDriver
    int idx;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    idx = 0;
    bus.data_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        1: begin
          bus.data_ready = pat[idx];
          idx = (idx + 1) % 4;
        end
        2:       bus.data_ready = 1'b0;
        default: bus.data_ready = 1'b1;
      endcase
    end
  end

  // Output compare: every valid cycle against the expected column queue.
  initial begin : comparer
    bit           lastHs, prevStall;
    int           col;
    logic [WC-1:0] prevCol;
    logic [Z-1:0]  prevOut;
    lastHs    = 1'b0;
    prevStall = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        lastHs    = 1'b0;
        prevStall = 1'b0;
      end else begin
        if (lastHs || bus.frame_done) begin
          checkOutput("frame_done_after_last", bus.frame_done, lastHs);
          checkOutput("in_ready_at_done", bus.llr_in_ready, 1);
        end
        lastHs = 1'b0;
        if (bus.data_valid) begin
          if (prevStall) begin
            checkOutput("stall_col_stable", bus.data_col, prevCol);
            checkOutput("stall_data_stable", bus.data_out, prevOut);
          end
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat: got col %0d, expected no beat", bus.data_col);
          end else begin
            col = expQ[0];
            checkOutput("data_col", bus.data_col, col);
            checkOutput("data_out", bus.data_out, hardOf(col));
            checkOutput("data_last", bus.data_last, col == expK - 1);
            if (bus.data_ready) begin
              void'(expQ.pop_front());
              beatCount++;
              lastHs = (col == expK - 1);
            end
          end
          prevStall = !bus.data_ready;
          prevCol   = bus.data_col;
          prevOut   = bus.data_out;
        end else begin
          prevStall = 1'b0;
        end
      end
    end
  end

  // Load one frame (mode 0 ascending, 1 descending, 2 sparse) and set up the expectations.
  task automatic applyStimulus(input int rate, input int iterMax, input int synd, input int mode);
    int             cols[$];
    logic [Z*W-1:0] v;
    case (mode)
      1:       for (int c = NC - 1; c >= 0; c--) cols.push_back(c);
      2:       begin cols.push_back(5); cols.push_back(9); end
      default: for (int c = 0; c < NC; c++) cols.push_back(c);
    endcase
    expK     = (rate == 0) ? 8 : (rate == 1) ? 10 : (rate == 2) ? 12 : 13;
    effMax   = (iterMax == 0) ? 1 : iterMax;
    syndAt   = synd;
    expEarly = (synd != 0) && (synd <= effMax);
    expIters = expEarly ? synd : effMax;
    startCount = 0;
    iterNum    = 0;
    beatCount  = 0;
    expQ.delete();
    for (int k = 0; k < expK; k++) expQ.push_back(k);
    for (int n = 0; n < cols.size(); n++) begin
      @(negedge clk);
      for (int i = 0; i < Z; i++) v[i*W +: W] = W'($urandom);
      bus.llr_in       = v;
      bus.llr_in_col   = WC'(cols[n]);
      bus.llr_in_valid = 1'b1;
      bus.llr_in_last  = (n == cols.size() - 1);
      bus.rate         = WR'(rate);
      bus.iter_max     = WI'(iterMax);
      #1;
      checkOutput("in_ready_load", bus.llr_in_ready, 1);
      chModel[cols[n]] = v;
      chValid[cols[n]] = 1'b1;
    end
    @(negedge clk);
    bus.llr_in_valid = 1'b0;
    bus.llr_in_last  = 1'b0;
    #1;
    checkOutput("start_after_last", bus.core_start, 1);
    checkOutput("in_ready_iter", bus.llr_in_ready, 0);
    for (int c = 0; c < NC; c++) begin
      if (chValid[c]) checkWide($sformatf("llr_ch_col%0d", c), bus.llr_ch[c*Z*W +: Z*W], chModel[c]);
    end
  endtask

  // Bounded wait for the frame_done pulse, then the frame-level statistics.
  task automatic waitFrameDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus.frame_done) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, seen, 1);
    checkOutput({tag, "_stat_iters"}, bus.stat_iters, expIters);
    checkOutput({tag, "_stat_early"}, bus.stat_early, expEarly);
    checkOutput({tag, "_starts"}, startCount, expIters);
    checkOutput({tag, "_beats"}, beatCount, expK);
    checkOutput({tag, "_queue_empty"}, expQ.size(), 0);
  endtask

  // Bounded wait for the first output beat.
  task automatic waitValid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); #1;
      if (bus.data_valid) seen = 1'b1;
    end
    checkOutput({tag, "_valid_seen"}, seen, 1);
  endtask

  // Bounded wait until the core model has seen a given number of launches.
  task automatic waitStarts(input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); #1;
      if (startCount >= n) seen = 1'b1;
    end
    checkOutput("starts_reached", seen, 1);
  endtask

  // One-cycle reset pulse followed by the post-reset output checks.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    reset            = 1'b1;
    bus.llr_in_valid = 1'b0;
    bus.llr_in_last  = 1'b0;
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput({tag, "_in_ready"}, bus.llr_in_ready, 1);
    checkOutput({tag, "_valid"}, bus.data_valid, 0);
    checkOutput({tag, "_start"}, bus.core_start, 0);
    checkOutput({tag, "_col"}, bus.data_col, 0);
    checkOutput({tag, "_stat_iters"}, bus.stat_iters, 0);
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput({tag, "_start_idle"}, bus.core_start, 0);
    end
  endtask

  // Directed frame sequence.
  initial begin : mainSeq
    reset            = 1'b1;
    readyMode        = 0;
    bus.rate         = '0;
    bus.iter_max     = '0;
    bus.llr_in       = '0;
    bus.llr_in_col   = '0;
    bus.llr_in_valid = 1'b0;
    bus.llr_in_last  = 1'b0;
    startCount = 0;
    iterNum    = 0;
    beatCount  = 0;
    syndAt     = 0;
    effMax     = 1;
    expK       = 8;
    for (int c = 0; c < NC; c++) begin
      chValid[c] = 1'b0;
      for (int i = 0; i < Z; i++) postVal[c][i] = int'($urandom_range(0, 62)) - 31;
    end
    postVal[0][0] = 5;
    postVal[0][1] = 0;
    postVal[0][2] = -1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", bus.llr_in_ready, 1);
    checkOutput("rst_core_start", bus.core_start, 0);
    checkOutput("rst_post_col_sel", bus.post_col_sel, 0);
    checkOutput("rst_data_valid", bus.data_valid, 0);
    checkOutput("rst_data_last", bus.data_last, 0);
    checkOutput("rst_data_col", bus.data_col, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    checkOutput("rst_stat_iters", bus.stat_iters, 0);
    checkOutput("rst_stat_early", bus.stat_early, 0);

    // Frame 1: rate 1/2, three iterations, no syndrome.
    $display("[TB] frame 1: rate 0, iter_max 3");
    applyStimulus(0, 3, 0, 0);
    waitValid("f1");
    checkOutput("f1_first_col", bus.data_col, 0);
    checkOutput("f1_lanes_5_0_m1", bus.data_out[2:0], 3'b110);
    waitFrameDone("f1");
    checkOutput("f1_iters_lit", bus.stat_iters, 3);
    checkOutput("f1_early_lit", bus.stat_early, 0);
    checkOutput("f1_starts_lit", startCount, 3);
    checkOutput("f1_beats_lit", beatCount, 8);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("f1_iters_hold", bus.stat_iters, 3);

    // Frame 2: rate 13/16, syndrome on the second iteration, stalled output.
    $display("[TB] frame 2: rate 3, early termination, ready 1,0,0,1");
    readyMode = 1;
    applyStimulus(3, 10, 2, 1);
    waitFrameDone("f2");
    checkOutput("f2_iters_lit", bus.stat_iters, 2);
    checkOutput("f2_early_lit", bus.stat_early, 1);
    checkOutput("f2_starts_lit", startCount, 2);
    checkOutput("f2_beats_lit", beatCount, 13);
    readyMode = 0;

    // Frame 3: rate 3/4, iter_max 0 acts as one, sparse column load.
    $display("[TB] frame 3: rate 2, iter_max 0, sparse load");
    applyStimulus(2, 0, 0, 2);
    waitFrameDone("f3");
    checkOutput("f3_iters_lit", bus.stat_iters, 1);
    checkOutput("f3_starts_lit", startCount, 1);
    checkOutput("f3_beats_lit", beatCount, 12);

    // Frame 4: reset in the middle of the iterations; a beat offered during ITER is refused.
    $display("[TB] frame 4: reset mid-ITER");
    applyStimulus(1, 10, 0, 0);
    waitStarts(2);
    @(negedge clk);
    bus.llr_in       = ~chModel[15];
    bus.llr_in_col   = WC'(15);
    bus.llr_in_valid = 1'b1;
    bus.llr_in_last  = 1'b1;
    #1;
    checkOutput("f4_ready_iter", bus.llr_in_ready, 0);
    pulseReset("f4_rst");
    checkWide("f4_col15_kept", bus.llr_ch[15*Z*W +: Z*W], chModel[15]);

    // Frame 5: reset while the output is held by backpressure.
    $display("[TB] frame 5: reset mid-OUT");
    readyMode = 2;
    applyStimulus(1, 2, 0, 0);
    waitValid("f5");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("f5_stalled_col", bus.data_col, 0);
    pulseReset("f5_rst");
    readyMode = 0;

    // Frame 6: normal decode after reset; syndrome on the final allowed iteration.
    $display("[TB] frame 6: rate 1, syndrome at limit");
    applyStimulus(1, 4, 4, 1);
    waitFrameDone("f6");
    checkOutput("f6_iters_lit", bus.stat_iters, 4);
    checkOutput("f6_early_lit", bus.stat_early, 1);
    checkOutput("f6_beats_lit", beatCount, 10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit in case a wait ever escapes its bound.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
